// File: rtl/pmem_prefetch_arbiter.sv
// pmem_prefetch_arbiter
//
// Shares the single cacheline-adapter port among the I-cache, the D-cache and
// the hardware prefetcher. Demand traffic (I/D) is arbitrated round-robin. A
// prefetch is granted only after the port has sat idle, with no demand
// pending, for PF_IDLE_CYCLES consecutive cycles. A grant lasts for exactly one
// line transfer, which ends on pmem_resp.
//
// Ports:
//   clk, rst                     clock; synchronous active-low reset
//   i_pmem_read/_address/_resp   I-cache line read channel
//   d_pmem_read/_write/_address/_wdata/_resp
//                                D-cache line read / writeback channel
//   pf_read/_address/_resp       prefetcher line read channel
//   pmem_rdata_out               adapter read data, broadcast to all requesters
//   pmem_read/_write/_address/_wdata
//                                request to the cacheline adapter
//   pmem_resp, pmem_rdata        response from the cacheline adapter
module pmem_prefetch_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_W         = 256,
    parameter int unsigned PF_IDLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,

    input  logic              pf_read,
    input  logic [ADDR_W-1:0] pf_address,
    output logic              pf_resp,

    output logic [LINE_W-1:0] pmem_rdata_out,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    localparam int unsigned CntW = (PF_IDLE_CYCLES == 0) ? 1 : $clog2(PF_IDLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(PF_IDLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StIBusy,
        StDBusy,
        StPBusy
    } state_e;

    state_e          state;
    logic            last_demand;  // 0 = I served last, 1 = D served last
    logic [CntW-1:0] idle_cnt;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            last_demand <= 1'b1;
            idle_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // I wins when D is absent or when D was the last demand owner.
                    if (i_req && (!d_req || last_demand)) begin
                        state       <= StIBusy;
                        last_demand <= 1'b0;
                        idle_cnt    <= '0;
                    end else if (d_req) begin
                        state       <= StDBusy;
                        last_demand <= 1'b1;
                        idle_cnt    <= '0;
                    end else if (pf_read && (idle_cnt >= CntMax)) begin
                        state    <= StPBusy;
                        idle_cnt <= '0;
                    end else if (idle_cnt != CntMax) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                StIBusy, StDBusy, StPBusy: begin
                    // A grant, prefetch included, is only released by the adapter.
                    if (pmem_resp) begin
                        state <= StIdle;
                    end
                    idle_cnt <= '0;
                end
                default: begin
                    state    <= StIdle;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    // Owner's channel is steered onto the adapter; everything is quiet in IDLE,
    // so a stray pmem_resp there reaches nobody.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        pf_resp      = 1'b0;
        unique case (state)
            StIBusy: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            StDBusy: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            StPBusy: begin
                pmem_read    = pf_read;
                pmem_address = pf_address;
                pf_resp      = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_rdata_out = pmem_rdata;

endmodule

// File: tb/tb_pmem_prefetch_arbiter.sv
// Self-checking bench for pmem_prefetch_arbiter: a cycle table from reset,
// directed multi-cycle sequences, then randomized traffic against a model.
module tb_pmem_prefetch_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned PF = 4;
    localparam logic [LW-1:0] A5 = {32{8'hA5}};
    localparam int NRAND = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic          d_pmem_resp;
    logic          pf_read;
    logic [AW-1:0] pf_address;
    logic          pf_resp;
    logic [LW-1:0] pmem_rdata_out;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    always #5 clk = ~clk;

    pmem_prefetch_arbiter #(
        .ADDR_W        (AW),
        .LINE_W        (LW),
        .PF_IDLE_CYCLES(PF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_pmem_read   (i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_resp   (i_pmem_resp),
        .d_pmem_read   (d_pmem_read),
        .d_pmem_write  (d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata  (d_pmem_wdata),
        .d_pmem_resp   (d_pmem_resp),
        .pf_read       (pf_read),
        .pf_address    (pf_address),
        .pf_resp       (pf_resp),
        .pmem_rdata_out(pmem_rdata_out),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // {pmem_read, pmem_write, i_resp, d_resp, pf_resp}
    function automatic logic [4:0] ctl();
        return {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pf_resp};
    endfunction

    task automatic clear_inputs();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        pf_read      = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Cycle table: inputs for the cycle and the owner whose channel should
    // appear on the port (0 none, 1 I, 2 D, 3 P).
    typedef struct packed {
        logic       i_rd;
        logic       d_rd;
        logic       d_wr;
        logic       pf;
        logic       resp;
        logic       e_rd;
        logic       e_wr;
        logic [1:0] e_own;
        logic [2:0] e_resp;  // {i, d, pf}
    } vec_t;

    vec_t vecs[22];

    function automatic logic [AW-1:0] own_addr(input logic [1:0] own);
        case (own)
            2'd1:    return 32'h100;
            2'd2:    return 32'h200;
            2'd3:    return 32'h300;
            default: return '0;
        endcase
    endfunction

    // Reference model state.
    int m_own;      // 0 none, 1 I, 2 D, 3 P
    int m_last_d;   // 1 when D was the last demand owner
    int m_quiet;    // consecutive demand-free idle cycles since the port went idle
    int m_nxt;
    logic          e_rd, e_wr, e_ir, e_dr, e_pr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    logic          i_act, d_act, pf_act;

    initial begin
        pmem_rdata     = '0;
        i_pmem_address = 32'h100;
        d_pmem_address = 32'h200;
        pf_address     = 32'h300;
        d_pmem_wdata   = A5;

        //            i d w p r | rd wr own resp
        vecs[0]  = '{1,1,0,0,0, 0,0,2'd0,3'b000};
        vecs[1]  = '{1,1,0,0,0, 1,0,2'd1,3'b000};
        vecs[2]  = '{1,1,0,0,0, 1,0,2'd1,3'b000};
        vecs[3]  = '{1,1,0,0,1, 1,0,2'd1,3'b100};
        vecs[4]  = '{1,1,0,0,0, 0,0,2'd0,3'b000};
        vecs[5]  = '{1,1,0,0,0, 1,0,2'd2,3'b000};
        vecs[6]  = '{1,1,0,0,1, 1,0,2'd2,3'b010};
        vecs[7]  = '{1,0,0,0,0, 0,0,2'd0,3'b000};
        vecs[8]  = '{1,0,0,0,1, 1,0,2'd1,3'b100};
        vecs[9]  = '{0,0,1,0,0, 0,0,2'd0,3'b000};
        vecs[10] = '{0,0,1,0,0, 0,1,2'd2,3'b000};
        vecs[11] = '{0,0,1,0,1, 0,1,2'd2,3'b010};
        vecs[12] = '{0,0,0,0,1, 0,0,2'd0,3'b000};
        vecs[13] = '{0,0,0,1,0, 0,0,2'd0,3'b000};
        vecs[14] = '{0,0,0,1,0, 0,0,2'd0,3'b000};
        vecs[15] = '{0,0,0,1,0, 0,0,2'd0,3'b000};
        vecs[16] = '{0,0,0,1,0, 0,0,2'd0,3'b000};
        vecs[17] = '{0,1,0,1,0, 1,0,2'd3,3'b000};
        vecs[18] = '{0,1,0,1,1, 1,0,2'd3,3'b001};
        vecs[19] = '{0,1,0,0,0, 0,0,2'd0,3'b000};
        vecs[20] = '{0,1,0,0,1, 1,0,2'd2,3'b010};
        vecs[21] = '{0,0,0,0,0, 0,0,2'd0,3'b000};

        do_reset();
        @(negedge clk);
        chk("reset.ctl", 5'(ctl()), 5'b0);
        chk("reset.addr", LW'(pmem_address), '0);
        next_cycle();

        // ---------------- table ----------------
        for (int k = 0; k < 22; k++) begin
            i_pmem_read  = vecs[k].i_rd;
            d_pmem_read  = vecs[k].d_rd;
            d_pmem_write = vecs[k].d_wr;
            pf_read      = vecs[k].pf;
            pmem_resp    = vecs[k].resp;
            @(negedge clk);
            chk($sformatf("vec%0d.ctl", k), 5'(ctl()),
                {vecs[k].e_rd, vecs[k].e_wr, vecs[k].e_resp});
            chk($sformatf("vec%0d.addr", k), LW'(pmem_address), LW'(own_addr(vecs[k].e_own)));
            chk($sformatf("vec%0d.wdata", k), pmem_wdata, (vecs[k].e_own == 2'd2) ? A5 : '0);
            next_cycle();
        end
        clear_inputs();

        // ---------------- reset mid-writeback, then tie ----------------
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h40;
        next_cycle();                      // granted at this edge
        @(negedge clk);
        chk("wb.busy.ctl", 5'(ctl()), 5'b01000);
        chk("wb.busy.addr", LW'(pmem_address), LW'(32'h40));
        chk("wb.busy.wdata", pmem_wdata, A5);
        next_cycle();
        rst = 1'b0;                        // still D_BUSY this cycle, no resp
        next_cycle();
        pmem_resp   = 1'b1;                // after reset edge: must be ignored
        i_pmem_read = 1'b1;
        @(negedge clk);
        chk("rstmid.ctl", 5'(ctl()), 5'b0);
        next_cycle();
        rst       = 1'b1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("rstmid.idle.ctl", 5'(ctl()), 5'b0);
        next_cycle();
        @(negedge clk);
        chk("rel.tie.ctl", 5'(ctl()), 5'b10000);
        chk("rel.tie.addr", LW'(pmem_address), LW'(32'h100));
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("rel.i.resp", 5'(ctl()), 5'b10100);
        next_cycle();
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b0;
        next_cycle();                      // idle turnaround, D granted
        @(negedge clk);
        chk("wb2.ctl", 5'(ctl()), 5'b01000);
        chk("wb2.wdata", pmem_wdata, A5);
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("wb2.resp", 5'(ctl()), 5'b01010);
        next_cycle();
        clear_inputs();
        d_pmem_address = 32'h200;

        // ---------------- throttle with demand injection ----------------
        for (int c = 0; c < 13; c++) begin
            pf_read     = 1'b1;
            d_pmem_read = (c >= 3 && c <= 5);
            pmem_resp   = (c == 5 || c == 12);
            @(negedge clk);
            chk($sformatf("thr%0d.ctl", c), 5'(ctl()),
                {((c == 4 || c == 5) || c >= 11), 1'b0, 1'b0, (c == 5), (c == 12)});
            chk($sformatf("thr%0d.addr", c), LW'(pmem_address),
                (c == 4 || c == 5) ? LW'(32'h200) : (c >= 11) ? LW'(32'h300) : '0);
            next_cycle();
        end
        clear_inputs();

        // ---------------- randomized against model ----------------
        do_reset();
        m_own = 0; m_last_d = 1; m_quiet = 0;
        i_act = 0; d_act = 0; pf_act = 0;
        for (int n = 0; n < NRAND; n++) begin
            if (!i_act && $urandom_range(3) == 0) begin
                i_act = 1; i_pmem_address = $urandom;
            end
            if (!d_act && $urandom_range(3) == 0) begin
                d_act = 1; d_pmem_address = $urandom;
                d_pmem_wdata = {8{$urandom}};
                d_pmem_write = $urandom_range(1);
            end
            if (!pf_act && $urandom_range(2) == 0) begin
                pf_act = 1; pf_address = $urandom;
            end else if (pf_act && m_own != 3 && $urandom_range(7) == 0) begin
                pf_act = 0;
            end
            i_pmem_read = i_act;
            d_pmem_read = d_act && !d_pmem_write;
            if (!d_act) d_pmem_write = 1'b0;
            pf_read     = pf_act;
            pmem_resp   = ($urandom_range(2) == 0);
            pmem_rdata  = {8{$urandom}};

            // expected outputs for the current owner
            e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
            e_ir = (m_own == 1) && pmem_resp;
            e_dr = (m_own == 2) && pmem_resp;
            e_pr = (m_own == 3) && pmem_resp;
            if (m_own == 1) begin
                e_rd = i_pmem_read; e_addr = i_pmem_address;
            end else if (m_own == 2) begin
                e_rd = d_pmem_read; e_wr = d_pmem_write;
                e_addr = d_pmem_address; e_wd = d_pmem_wdata;
            end else if (m_own == 3) begin
                e_rd = pf_read; e_addr = pf_address;
            end

            @(negedge clk);
            chk($sformatf("rnd%0d.ctl", n), 5'(ctl()), {e_rd, e_wr, e_ir, e_dr, e_pr});
            chk($sformatf("rnd%0d.addr", n), LW'(pmem_address), LW'(e_addr));
            chk($sformatf("rnd%0d.wdata", n), pmem_wdata, e_wd);
            chk($sformatf("rnd%0d.rdata", n), pmem_rdata_out, pmem_rdata);

            // next owner from the arbitration rules
            if (m_own == 0) begin
                if (i_pmem_read && (d_pmem_read || d_pmem_write))
                    m_nxt = m_last_d ? 1 : 2;
                else if (i_pmem_read) m_nxt = 1;
                else if (d_pmem_read || d_pmem_write) m_nxt = 2;
                else if (pf_read && m_quiet >= int'(PF)) m_nxt = 3;
                else m_nxt = 0;
                if (m_nxt == 1) m_last_d = 0;
                if (m_nxt == 2) m_last_d = 1;
                m_quiet = (m_nxt == 0 && !(i_pmem_read || d_pmem_read || d_pmem_write))
                          ? m_quiet + 1 : 0;
            end else begin
                m_nxt   = pmem_resp ? 0 : m_own;
                m_quiet = 0;
            end
            if (e_ir) i_act = 0;
            if (e_dr) d_act = 0;
            if (e_pr) pf_act = 0;

            next_cycle();
            m_own = m_nxt;
        end
        clear_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
